// File: rtl/npc_pkg.sv
// Shared definitions for the npc control path.
// Holds the grant FSM state encoding used by irq_pending_arbiter.
package npc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } grant_state_t;

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// Grant handshake between irq_pending_arbiter (master) and its consumer (slave).
//   valid : idx holds a pending request
//   idx   : index of the granted line
//   ready : consumer accepts idx this cycle
interface irq_pending_arbiter_if #(
  parameter int N = 3
);
  logic         valid;
  logic [N-1:0] idx;
  logic         ready;

  modport master (output valid, output idx, input ready);
  modport slave  (input valid, input idx, output ready);
endinterface

// File: rtl/encoder_priority.sv
// Priority encoder: highest set index of din wins.
//   en   : encoder enable (dout = 0, vld = 0 when low)
//   din  : M request bits
//   dout : N-bit index of the highest set bit
//   vld  : any bit of din set
module encoder_priority #(
  parameter int M = 8,
  parameter int N = 3
) (
  input  logic         en,
  input  logic [M-1:0] din,
  output logic [N-1:0] dout,
  output logic         vld
);

  always_comb begin
    dout = '0;
    vld  = 1'b0;
    if (en) begin
      // Ascending scan: the last match, i.e. the highest index, is kept.
      for (int unsigned i = 0; i < M; i++) begin
        if (din[i]) begin
          dout = N'(i);
          vld  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/irq_pending_arbiter.sv
// Interrupt/event front end: captures request pulses into a sticky pending
// register, grants the highest pending index over a valid/ready handshake
// and clears the granted bit on acceptance.
//   clk, rst : clock, synchronous active-high reset
//   en       : capture enable (handshake unaffected)
//   req      : M request lines
//   clr_ovf  : clears ovf
//   pending  : pending register
//   ovf      : sticky lost-request flag
//   grant    : valid/idx/ready handshake (master side)
module irq_pending_arbiter
  import npc_pkg::*;
#(
  parameter int M    = 8,
  parameter int N    = 3,
  parameter int EDGE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [M-1:0]          req,
  input  logic                  clr_ovf,
  output logic [M-1:0]          pending,
  output logic                  ovf,
  irq_pending_arbiter_if.master grant
);

  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  grant_state_t state;
  logic         valid_q;
  logic [N-1:0] idx_q;
  logic [M-1:0] pending_q;
  logic         ovf_q;
  logic [M-1:0] req_d;

  logic [M-1:0] cap;
  logic [M-1:0] idx_onehot;
  logic [M-1:0] clr;
  logic [M-1:0] enc_in;
  logic [N-1:0] enc_idx;
  logic         enc_vld;

  always_comb begin
    cap = '0;
    if (en) cap = (EDGE != 0) ? (req & ~req_d) : req;
  end

  assign idx_onehot = ONE << idx_q;
  assign clr        = (valid_q && grant.ready) ? idx_onehot : '0;

  // In HOLD the line currently presented is excluded so an acceptance can
  // hand over the next grant in the same cycle.
  assign enc_in = (state == HOLD) ? (pending_q & ~idx_onehot) : pending_q;

  encoder_priority #(.M(M), .N(N)) u_enc (
    .en   (1'b1),
    .din  (enc_in),
    .dout (enc_idx),
    .vld  (enc_vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      valid_q   <= 1'b0;
      idx_q     <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      req_d     <= '0;
    end else begin
      req_d     <= req;
      pending_q <= (pending_q & ~clr) | cap;

      // A capture on the bit being cleared this cycle is not a loss.
      if (|(cap & pending_q & ~clr)) ovf_q <= 1'b1;
      else if (clr_ovf)              ovf_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (|pending_q) begin
            state   <= HOLD;
            valid_q <= 1'b1;
            idx_q   <= enc_idx;
          end
        end
        HOLD: begin
          if (grant.ready) begin
            if (enc_vld) begin
              idx_q <= enc_idx;
            end else begin
              state   <= IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant.valid = valid_q;
  assign grant.idx   = idx_q;
  assign pending     = pending_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
module tb_irq_pending_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;
  logic       ready;
  logic       clr_ovf;

  logic [7:0] pending1, pending0;
  logic       ovf1, ovf0;

  irq_pending_arbiter_if #(.N(3)) g1 ();
  irq_pending_arbiter_if #(.N(3)) g0 ();
  assign g1.ready = ready;
  assign g0.ready = ready;

  irq_pending_arbiter #(.M(8), .N(3), .EDGE(1)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .clr_ovf(clr_ovf),
    .pending(pending1), .ovf(ovf1), .grant(g1)
  );

  irq_pending_arbiter #(.M(8), .N(3), .EDGE(0)) dut_lvl (
    .clk(clk), .rst(rst), .en(en), .req(req), .clr_ovf(clr_ovf),
    .pending(pending0), .ovf(ovf0), .grant(g0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       ready;
    logic       clr_ovf;
    logic       e_valid;
    logic [2:0] e_idx;
    logic [7:0] e_pend;
    logic       e_ovf;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(input logic r, input logic e, input logic [7:0] q,
                              input logic rd, input logic co, input logic ev,
                              input logic [2:0] ei, input logic [7:0] ep,
                              input logic eo);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.ready = rd; t.clr_ovf = co;
    t.e_valid = ev; t.e_idx = ei; t.e_pend = ep; t.e_ovf = eo;
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int grants1, grants0;
  int bad_idx;

  initial begin
    rst = 1'b1; en = 1'b1; req = '0; ready = 1'b0; clr_ovf = 1'b0;

    //           rst en  req    rdy clr  valid idx pend  ovf
    // reset
    v.push_back(mk(1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0));
    // single request
    v.push_back(mk(0, 1, 8'h10, 1, 0, 0, 0, 8'h10, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 1, 4, 8'h10, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 0, 4, 8'h00, 0));
    // priority and back-to-back
    v.push_back(mk(0, 1, 8'h25, 1, 0, 0, 4, 8'h25, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 1, 5, 8'h25, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 1, 2, 8'h05, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 1, 0, 8'h01, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    // hold stability
    v.push_back(mk(0, 1, 8'h02, 0, 0, 0, 0, 8'h02, 0));
    v.push_back(mk(0, 1, 8'h00, 0, 0, 1, 1, 8'h02, 0));
    v.push_back(mk(0, 1, 8'h80, 0, 0, 1, 1, 8'h82, 0));
    for (int i = 0; i < 4; i++)
      v.push_back(mk(0, 1, 8'h00, 0, 0, 1, 1, 8'h82, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 1, 7, 8'h80, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 0, 7, 8'h00, 0));
    // overflow
    v.push_back(mk(0, 1, 8'h08, 0, 0, 0, 7, 8'h08, 0));
    v.push_back(mk(0, 1, 8'h00, 0, 0, 1, 3, 8'h08, 0));
    v.push_back(mk(0, 1, 8'h08, 0, 0, 1, 3, 8'h08, 1));
    v.push_back(mk(0, 1, 8'h00, 0, 1, 1, 3, 8'h08, 0));
    v.push_back(mk(0, 1, 8'h08, 0, 1, 1, 3, 8'h08, 1));   // set beats clr_ovf
    v.push_back(mk(0, 1, 8'h00, 0, 1, 1, 3, 8'h08, 0));
    v.push_back(mk(0, 1, 8'h08, 1, 0, 0, 3, 8'h08, 0));   // re-pulse on accept
    v.push_back(mk(0, 1, 8'h00, 0, 0, 1, 3, 8'h08, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 0, 3, 8'h00, 0));
    // enable low drops requests
    v.push_back(mk(0, 0, 8'hFF, 0, 0, 0, 3, 8'h00, 0));
    v.push_back(mk(0, 0, 8'h00, 0, 0, 0, 3, 8'h00, 0));
    // reset mid-operation, acceptance in the reset cycle is lost
    v.push_back(mk(0, 1, 8'h0F, 0, 0, 0, 3, 8'h0F, 0));
    v.push_back(mk(0, 1, 8'h00, 0, 0, 1, 3, 8'h0F, 0));
    v.push_back(mk(1, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0));
    v.push_back(mk(0, 1, 8'h00, 1, 0, 0, 0, 8'h00, 0));

    foreach (v[i]) begin
      rst = v[i].rst; en = v[i].en; req = v[i].req;
      ready = v[i].ready; clr_ovf = v[i].clr_ovf;
      step();
      check($sformatf("v%0d valid", i), int'(g1.valid), int'(v[i].e_valid));
      check($sformatf("v%0d idx", i), int'(g1.idx), int'(v[i].e_idx));
      check($sformatf("v%0d pending", i), int'(pending1), int'(v[i].e_pend));
      check($sformatf("v%0d ovf", i), int'(ovf1), int'(v[i].e_ovf));
    end

    // Level held on req[6] for 10 cycles: edge mode grants once, level mode repeatedly.
    rst = 1'b1; en = 1'b1; req = '0; ready = 1'b1; clr_ovf = 1'b0;
    step();
    rst = 1'b0;
    grants1 = 0; grants0 = 0; bad_idx = 0;
    for (int c = 0; c < 16; c++) begin
      req = (c < 10) ? 8'h40 : 8'h00;
      step();
      if (g1.valid) begin
        grants1++;
        if (g1.idx != 3'd6) bad_idx++;
      end
      if (g0.valid) begin
        grants0++;
        if (g0.idx != 3'd6) bad_idx++;
      end
    end
    check("edge_grants", grants1, 1);
    check("level_multi", int'(grants0 >= 2), 1);
    check("held_idx", bad_idx, 0);
    check("edge_drained", int'(pending1), 0);
    check("level_drained", int'(pending0), 0);

    // Throughput: three bits pending before grant, one grant per cycle, then IDLE.
    ready = 1'b1; req = 8'h92;
    step();
    req = 8'h00;
    step();
    check("tp_g0", int'(g1.valid) * 16 + int'(g1.idx), 16 + 7);
    step();
    check("tp_g1", int'(g1.valid) * 16 + int'(g1.idx), 16 + 4);
    step();
    check("tp_g2", int'(g1.valid) * 16 + int'(g1.idx), 16 + 1);
    step();
    check("tp_idle", int'(g1.valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_pending_arbiter.md
# irq_pending_arbiter

Captures request pulses on M input lines into a sticky pending register and picks the highest-index pending line with the `encoder_priority` encoder. It presents that index to a downstream consumer over a valid/ready handshake and clears the pending bit when the consumer accepts it. The block sits directly upstream of the priority encoder, wrapping it with capture, hold and clear logic. It is the interrupt/event front end of the npc control path.

## Interface
Parameters:
- `M`, 8, number of request lines
- `N`, 3, index width; requires 2^N >= M
- `EDGE`, 1, 1 = capture rising edges of `req`, 0 = capture any cycle `req` is high

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset; synchronous, active-high
- `en`  in  1  capture enable; when low, new requests are dropped and the handshake continues
- `req`  in  M  request lines
- `ready`  in  1  consumer accepts `idx` this cycle
- `clr_ovf`  in  1  clears `ovf`
- `valid`  out  1  `idx` holds a pending request
- `idx`  out  N  index of the granted line
- `pending`  out  M  pending register
- `ovf`  out  1  sticky flag: a request was lost because its bit was already pending

## Operation
- `req_d` is `req` delayed one cycle (reset value 0).
- `cap` = `EDGE ? (req & ~req_d) : req`, gated by `en`.
- `clr` = one-hot of `idx` when `valid && ready`, otherwise 0.
- `pending` next = `(pending & ~clr) | cap`.
  - A capture on the bit being cleared in the same cycle wins: the bit stays set and `ovf` is not raised.
- `ovf` next = `1` if any bit in `cap & pending & ~clr`; `0` if `clr_ovf`; otherwise hold.
  - Set has priority over `clr_ovf` in the same cycle.
- Encoder input `enc_in` = `pending & ~onehot(idx)` in HOLD, `pending` in IDLE. The highest set index wins; `en` of the encoder is tied to 1.
- FSM:
  - IDLE (`valid`=0): if `pending` != 0, go to HOLD and `idx` <= enc(`enc_in`); otherwise stay.
  - HOLD (`valid`=1): `idx` is frozen while `ready`=0, even if a higher line becomes pending.
    - On `ready`=1 with `enc_in` != 0: stay in HOLD and load `idx` <= enc(`enc_in`) (back-to-back grant).
    - On `ready`=1 with `enc_in` == 0: go to IDLE.
- Requests captured in the acceptance cycle are not part of `enc_in`. They are seen one cycle later through IDLE.

## Timing
- Reset values: state IDLE, `valid`=0, `idx`=0, `pending`=0, `ovf`=0, `req_d`=0.
- Latency from `req` high at edge t to `pending` bit set after t is 1 cycle. `valid` rises after edge t+1, a 2-cycle latency from request to grant.
- Throughput: with more than one bit already pending, one grant per cycle. After the last bit drains, there is one IDLE bubble before newly captured requests are granted.
- `valid`/`idx` are registered outputs. `valid` never drops without `ready`. `idx` never changes while `valid && !ready`.
- `rst` mid-handshake clears everything at that edge. An acceptance in the same cycle as `rst` is lost.
- `en` low does not affect `ready`/`clr` or state transitions.
- An `EDGE`=1 level held high produces exactly one capture.

## Structure
- Shared package (`npc_pkg`): IDLE/HOLD state encoding constant. Nothing else is shared.
- Instantiates `encoder_priority #(.M(M), .N(N))` once, fed by the `enc_in` mux. No other sub-module.
- `onehot(idx)` is a local shift `1 << idx`, sized M.

## Test plan
- Single request, M=8, EDGE=1: `req`=8'h10 for one cycle, `ready`=1.
  - `pending`=8'h10 after 1 cycle; `valid`=1, `idx`=4 after 2 cycles; next cycle `valid`=0, `pending`=0.
- Priority and back-to-back: `req`=8'h25 in one cycle, `ready` held 1.
  - Grants `idx`=5, 2, 0 on three consecutive cycles, then `valid`=0.
- Hold stability: `req`=8'h02, `ready`=0 until `valid`. Then pulse `req`=8'h80 while `ready`=0 for 5 cycles, then `ready`=1.
  - `idx` stays 1 during the stall; the next grant is `idx`=7.
- Overflow: with bit 3 pending and `ready`=0, pulse `req[3]` again.
  - `ovf`=1 next cycle. `clr_ovf` clears it.
  - A re-pulse of bit 3 in the same cycle it is accepted leaves `pending[3]`=1 and `ovf`=0.
- Enable and edge mode: with `en`=0, pulse `req`=8'hFF → `pending` stays 0. With EDGE=1, `req[6]` held high for 10 cycles → exactly one grant of `idx`=6. With EDGE=0, the same stimulus gives repeated grants.
- Reset mid-operation: with `pending`=8'h0F and `valid`=1, assert `rst` for one cycle.
  - All outputs are 0 the next cycle; there are no grants until a new request arrives.
